// File: rtl/resonator3_inverse_pkg.sv
// Shared constants for the resonator3_inverse datapath.
// Holds the sample, coefficient, accumulator and output widths, the
// rounding constants for Q17 coefficient products, and the pipeline depth.
package resonator3_inverse_pkg;
    localparam int DATA_W     = 18;               // input sample width
    localparam int COEF_W     = 17;               // cm1 / d width (Q17)
    localparam int ACC_W      = 22;               // integrator width
    localparam int OUT_W      = 16;               // output sample width
    localparam int F_W        = 21;               // numerator sum width
    localparam int PROD_W     = DATA_W + COEF_W;  // full product width
    localparam int ROUND_OFS  = 65536;            // half LSB after the shift
    localparam int COEF_SHIFT = 17;
    localparam int STAGES     = 4;                // iv -> ov latency in clocks
endpackage

// File: rtl/resonator3_inverse_sat_clamp.sv
// sat_clamp: generic signed saturation from IN_W bits down to OUT_W bits.
// Ports:
//   din  - signed IN_W-bit value
//   dout - din clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sat_clamp #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 22
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(64'sd1 <<< (OUT_W - 1)));

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/resonator3_inverse.sv
// resonator3_inverse: inverse of the 3-pole resonator,
//   H(z) = (1 - z^-1 + c*z^-2 + d*z^-3) / (1 - z^-1),  c = 1 + cm1.
// Four-clock pipeline: delay-line capture, registered products, numerator
// sum, saturating integrator; the output register follows the integrator.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   iv, inp          - input strobe and signed 18-bit sample
//   cm1, d           - Q17 coefficients, captured on coef_load
//   coef_load        - latch cm1/d into the shadow registers
//   zerome           - synchronous clear of history, integrator and pipeline
//   ov, out, clip    - output strobe, saturated 16-bit sample, clamp flag
//   clip_cnt         - saturating count of clipped outputs
module resonator3_inverse
    import resonator3_inverse_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iv,
    input  logic signed [DATA_W-1:0] inp,
    input  logic signed [COEF_W-1:0] cm1,
    input  logic signed [COEF_W-1:0] d,
    input  logic                     coef_load,
    input  logic                     zerome,
    output logic                     ov,
    output logic signed [OUT_W-1:0]  out,
    output logic                     clip,
    output logic [15:0]              clip_cnt
);
    // Round half up and drop the Q17 fraction of a coefficient product.
    function automatic logic signed [F_W-1:0] rnd(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] t;
        t   = (PROD_W + 1)'(p) + (PROD_W + 1)'(ROUND_OFS);
        rnd = F_W'(t >>> COEF_SHIFT);
    endfunction

    logic signed [COEF_W-1:0] cm1_sh, d_sh;
    logic signed [DATA_W-1:0] x1, x2, x3;
    logic                     vld_p0, vld_p1, vld_p2, vld_p3;

    logic signed [F_W-1:0]    lin_p0;
    logic signed [DATA_W-1:0] x2_p0, x3_p0;
    logic signed [COEF_W-1:0] cm1_p0, d_p0;
    logic signed [PROD_W-1:0] prod_c_p1, prod_d_p1;
    logic signed [F_W-1:0]    lin_p1;
    logic signed [F_W-1:0]    f_p2;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [OUT_W-1:0]  out_next;
    logic                     clip_next;

    assign acc_sum   = (ACC_W + 1)'(acc) + (ACC_W + 1)'(f_p2);
    assign clip_next = (ACC_W'(out_next) != acc);

    sat_clamp #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_sat_acc (
        .din  (acc_sum),
        .dout (acc_next)
    );

    sat_clamp #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_out (
        .din  (acc),
        .dout (out_next)
    );

    // Data-only pipeline registers; qualified by the vld_pN chain.
    always_ff @(posedge clk) begin
        // p0: linear part of the numerator and operands for the products
        lin_p0    <= F_W'(inp) - F_W'(x1) + F_W'(x2);
        x2_p0     <= x2;
        x3_p0     <= x3;
        cm1_p0    <= cm1_sh;
        d_p0      <= d_sh;
        // p1: registered products
        prod_c_p1 <= PROD_W'(cm1_p0) * PROD_W'(x2_p0);
        prod_d_p1 <= PROD_W'(d_p0) * PROD_W'(x3_p0);
        lin_p1    <= lin_p0;
        // p2: full numerator f
        f_p2      <= lin_p1 + rnd(prod_c_p1) + rnd(prod_d_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm1_sh   <= '0;
            d_sh     <= '0;
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            acc      <= '0;
            ov       <= 1'b0;
            out      <= '0;
            clip     <= 1'b0;
            clip_cnt <= '0;
        end else begin
            if (coef_load) begin
                cm1_sh <= cm1;
                d_sh   <= d;
            end
            // zerome has priority over a coincident iv: the sample is dropped
            if (zerome) begin
                x1 <= '0;
                x2 <= '0;
                x3 <= '0;
            end else if (iv) begin
                x1 <= inp;
                x2 <= x1;
                x3 <= x2;
            end
            vld_p0 <= iv && !zerome;
            vld_p1 <= vld_p0 && !zerome;
            vld_p2 <= vld_p1 && !zerome;
            // p3: saturating integrator
            vld_p3 <= vld_p2 && !zerome;
            if (zerome) begin
                acc <= '0;
            end else if (vld_p2) begin
                acc <= acc_next;
            end
            // output register: out/clip only move on a delivered sample
            ov <= vld_p3 && !zerome;
            if (vld_p3 && !zerome) begin
                out  <= out_next;
                clip <= clip_next;
                if (clip_next && clip_cnt != 16'hFFFF) begin
                    clip_cnt <= clip_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_resonator3_inverse.sv
module tb_resonator3_inverse;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               iv;
    logic signed [17:0] inp;
    logic signed [16:0] cm1;
    logic signed [16:0] d;
    logic               coef_load;
    logic               zerome;
    logic               ov;
    logic signed [15:0] out;
    logic               clip;
    logic [15:0]        clip_cnt;

    resonator3_inverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iv        (iv),
        .inp       (inp),
        .cm1       (cm1),
        .d         (d),
        .coef_load (coef_load),
        .zerome    (zerome),
        .ov        (ov),
        .out       (out),
        .clip      (clip),
        .clip_cnt  (clip_cnt)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    longint cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        longint o;
        bit     c;
        longint cap;
    } exp_t;
    exp_t sb[$];

    // Reference model state: accepted-sample history, integrator, coefficients
    longint h1 = 0, h2 = 0, h3 = 0, macc = 0, mc = 0, md = 0;

    // Monitor-side expectations
    longint last_out = 0;
    bit     last_clip = 0;
    longint exp_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic longint rndq(input longint p);
        return (p + 65536) >>> 17;
    endfunction

    // One clock of stimulus; the model is updated in the same slot.
    task automatic step(input bit v, input int x, input bit ld, input int c, input int dd, input bit z);
        longint cap, f;
        exp_t e;
        iv = v; inp = 18'(x); coef_load = ld; cm1 = 17'(c); d = 17'(dd); zerome = z;
        cap = cyc + 1;
        if (z) begin
            while (sb.size() > 0 && sb[sb.size()-1].cap >= cap - 4) void'(sb.pop_back());
            h1 = 0; h2 = 0; h3 = 0; macc = 0;
        end else if (v) begin
            f = x - h1 + h2 + rndq(mc * h2) + rndq(md * h3);
            macc = clampv(macc + f, -(64'sd1 <<< 21), (64'sd1 <<< 21) - 1);
            e.o = clampv(macc, -32768, 32767);
            e.c = (e.o != macc);
            e.cap = cap;
            sb.push_back(e);
            h3 = h2; h2 = h1; h1 = x;
        end
        if (ld) begin
            mc = c; md = dd;
        end
        @(posedge clk); #1;
        iv = 0; coef_load = 0; zerome = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        sb.delete();
        h1 = 0; h2 = 0; h3 = 0; macc = 0; mc = 0; md = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_ov", ov, 0);
            chk("rst_out", out, 0);
            chk("rst_clip", clip, 0);
            chk("rst_clip_cnt", clip_cnt, 0);
            exp_cnt = 0; last_out = 0; last_clip = 0;
        end else if (ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_ov", 1, 0);
            end else begin
                e = sb.pop_front();
                if (e.c && exp_cnt < 65535) exp_cnt++;
                chk("ov_latency", cyc, e.cap + 4);
                chk("out", out, e.o);
                chk("clip", clip, e.c);
                chk("clip_cnt", clip_cnt, exp_cnt);
                last_out = e.o; last_clip = e.c;
            end
        end else begin
            chk("out_hold", out, last_out);
            chk("clip_hold", clip, last_clip);
            chk("clip_cnt_hold", clip_cnt, exp_cnt);
        end
    end

    initial begin
        rst_n = 0; iv = 0; inp = '0; cm1 = '0; d = '0; coef_load = 0; zerome = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Impulse response: expected 1000, 0, 1000, 1000, 1000
        step(1, 1000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);

        // Coefficient timing: c changes to 0.5 from sample 3
        step(0, 0, 0, 0, 0, 1);
        step(1, 1000, 0, 0, 0, 0);
        step(1, 1000, 0, 0, 0, 0);
        step(0, 0, 1, -65536, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1000, 0, 0, 0, 0);
        idle(6);

        // Clear/collision after nonzero history, then inp=500 -> out=500
        step(1, 1234, 0, 0, 0, 0);
        step(1, 777, 0, 0, 0, 1);
        step(1, 500, 0, 0, 0, 0);
        idle(6);

        // Clipping and clip_cnt saturation
        step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 65540; i++) step(1, 131071, 0, 0, 0, 0);
        idle(6);

        // Reset with three samples in flight
        step(1, 3000, 0, 0, 0, 0);
        step(1, -4000, 0, 0, 0, 0);
        step(1, 5000, 0, 0, 0, 0);
        pulse_reset();
        step(1, -200, 0, 0, 0, 0);
        idle(6);

        // Round trip of a 1/7 fS sine, amplitude 20000
        step(0, 0, 1, 0, 0, 1);
        for (int n = 0; n < 140; n++)
            step(1, $rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * n / 7.0)), 0, 0, 0, 0);
        idle(6);

        // Random traffic with coefficient loads and clears
        for (int n = 0; n < 2000; n++)
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 262143)) - 131072,
                 $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536,
                 $urandom_range(0, 63) == 0);
        idle(8);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
